// File: rtl/multi_sync_debounce.sv
// Multi-channel input conditioner for asynchronous pins: synchroniser chain,
// debounce filter, registered edge pulses and per-channel saturating rise counters.
module multi_sync_debounce #(
    parameter  int WIDTH    = 4,
    parameter  int STAGES   = 2,
    parameter  int DEBOUNCE = 1,
    parameter  int CNT_W    = 8,
    localparam int SEL_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] sig_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out,
    input  logic [SEL_W-1:0] cnt_sel,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_sat
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] s;

    logic [DB_W-1:0]  db_q [WIDTH];
    logic [DB_W-1:0]  db_d [WIDTH];
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic             cnt_sat_q, cnt_sat_d;

    // Plain flop chain: nothing may sit between stages.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= sig_in;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[STAGES-1];

    always_comb begin
        sig_d  = sig_q;
        rise_d = '0;
        fall_d = '0;
        for (int c = 0; c < WIDTH; c++) begin
            db_d[c] = '0;
            if (s[c] != sig_q[c]) begin
                if (db_q[c] == DB_LAST) begin
                    sig_d[c]  = s[c];
                    rise_d[c] = s[c];
                    fall_d[c] = !s[c];
                end else begin
                    db_d[c] = db_q[c] + DB_W'(1);
                end
            end
        end
    end

    // A clear coinciding with a rise loads 1 so the event is not lost.
    always_comb begin
        for (int c = 0; c < WIDTH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (cnt_clr && (int'(cnt_sel) == c)) begin
                cnt_d[c] = rise_q[c] ? CNT_W'(1) : '0;
            end else if (rise_q[c] && !(&cnt_q[c])) begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cnt_out_d = '0;
        for (int c = 0; c < WIDTH; c++) begin
            if (int'(cnt_sel) == c) cnt_out_d = cnt_q[c];
        end
        cnt_sat_d = &cnt_out_d;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sig_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            cnt_out_q <= '0;
            cnt_sat_q <= 1'b0;
            for (int c = 0; c < WIDTH; c++) begin
                db_q[c]  <= '0;
                cnt_q[c] <= '0;
            end
        end else begin
            sig_q     <= sig_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            cnt_out_q <= cnt_out_d;
            cnt_sat_q <= cnt_sat_d;
            for (int c = 0; c < WIDTH; c++) begin
                db_q[c]  <= db_d[c];
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign sig_out  = sig_q;
    assign rise_out = rise_q;
    assign fall_out = fall_q;
    assign cnt_out  = cnt_out_q;
    assign cnt_sat  = cnt_sat_q;

endmodule

// File: tb/tb_multi_sync_debounce.sv
// Directed bench for multi_sync_debounce: two instances cover latency,
// saturation, debounce filtering, clear/select and asynchronous reset.
module tb_multi_sync_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=4 STAGES=2 DEBOUNCE=1 CNT_W=2
    logic       rst_a;
    logic [3:0] sig_in_a, sig_out_a, rise_a, fall_a;
    logic [1:0] cnt_sel_a, cnt_out_a;
    logic       cnt_clr_a, cnt_sat_a;

    // Instance B: WIDTH=3 STAGES=3 DEBOUNCE=4 CNT_W=8
    logic       rst_b;
    logic [2:0] sig_in_b, sig_out_b, rise_b, fall_b;
    logic [1:0] cnt_sel_b;
    logic [7:0] cnt_out_b;
    logic       cnt_clr_b, cnt_sat_b;

    multi_sync_debounce #(
        .WIDTH(4), .STAGES(2), .DEBOUNCE(1), .CNT_W(2)
    ) u_a (
        .clk_in(clk), .rst_in(rst_a), .sig_in(sig_in_a),
        .sig_out(sig_out_a), .rise_out(rise_a), .fall_out(fall_a),
        .cnt_sel(cnt_sel_a), .cnt_clr(cnt_clr_a),
        .cnt_out(cnt_out_a), .cnt_sat(cnt_sat_a)
    );

    multi_sync_debounce #(
        .WIDTH(3), .STAGES(3), .DEBOUNCE(4), .CNT_W(8)
    ) u_b (
        .clk_in(clk), .rst_in(rst_b), .sig_in(sig_in_b),
        .sig_out(sig_out_b), .rise_out(rise_b), .fall_out(fall_b),
        .cnt_sel(cnt_sel_b), .cnt_clr(cnt_clr_b),
        .cnt_out(cnt_out_b), .cnt_sat(cnt_sat_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  nrise;
    bit  both;

    initial begin
        rst_a = 1'b1; sig_in_a = 4'hF; cnt_sel_a = '0; cnt_clr_a = 1'b0;
        rst_b = 1'b1; sig_in_b = '0;   cnt_sel_b = '0; cnt_clr_b = 1'b0;
        tick(); tick();
        check("rst_sig_a",  sig_out_a, 0);
        check("rst_rise_a", rise_a,    0);
        check("rst_fall_a", fall_a,    0);
        check("rst_cnt_a",  cnt_out_a, 0);
        check("rst_sat_a",  cnt_sat_a, 0);
        check("rst_sig_b",  sig_out_b, 0);
        sig_in_a = '0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick(); tick(); tick();

        // Latency: driven after edge 0, captured edge 1, output edge 3
        sig_in_a[0] = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("lat_sig_e%0d", e), sig_out_a[0], e >= 3);
            check($sformatf("lat_rise_e%0d", e), rise_a[0], e == 3);
            check($sformatf("lat_cnt_e%0d", e), cnt_out_a, (e >= 5) ? 1 : 0);
        end

        // Saturation: 5 rises on ch2 with a 2-bit counter
        for (int r = 0; r < 5; r++) begin
            sig_in_a[2] = 1'b1;
            tick(); tick(); tick();
            sig_in_a[2] = 1'b0;
            tick(); tick(); tick();
        end
        cnt_sel_a = 2'd2;
        tick(); tick(); tick(); tick();
        check("sat_cnt", cnt_out_a, 3);
        check("sat_flag", cnt_sat_a, 1);

        // Clear coinciding with a rise increment
        sig_in_a[2] = 1'b1;
        tick(); tick(); tick();
        check("clr_rise_pulse", rise_a[2], 1);
        cnt_clr_a = 1'b1;
        tick();
        cnt_clr_a = 1'b0;
        check("clr_old_read", cnt_out_a, 3);
        tick();
        check("clr_rise_cnt", cnt_out_a, 1);
        check("clr_rise_sat", cnt_sat_a, 0);

        // Debounce: 3-cycle glitch on ch1 must not pass
        sig_in_b[1] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check($sformatf("gl_sig_e%0d", e), sig_out_b[1], 0);
            check($sformatf("gl_rise_e%0d", e), rise_b[1], 0);
            if (e == 3) sig_in_b[1] = 1'b0;
        end

        // Debounce: 6-cycle pulse on ch0/ch1 passes intact
        sig_in_b = 3'b011;
        for (int e = 1; e <= 15; e++) begin
            tick();
            check($sformatf("pl_sig_e%0d", e), sig_out_b[1], (e >= 7) && (e <= 12));
            check($sformatf("pl_rise_e%0d", e), rise_b[1], e == 7);
            check($sformatf("pl_fall_e%0d", e), fall_b[1], e == 13);
            if (e == 6) sig_in_b = 3'b000;
        end

        // Out-of-range select: reads 0, clear ignored
        cnt_sel_b = 2'd3;
        cnt_clr_b = 1'b1;
        tick();
        cnt_clr_b = 1'b0;
        tick();
        check("oor_cnt", cnt_out_b, 0);
        check("oor_sat", cnt_sat_b, 0);
        cnt_sel_b = 2'd0;
        tick();
        check("ch0_before", cnt_out_b, 1);
        cnt_sel_b = 2'd1;
        tick();
        check("ch1_before", cnt_out_b, 1);
        cnt_clr_b = 1'b1;
        tick();
        cnt_clr_b = 1'b0;
        tick();
        check("ch1_cleared", cnt_out_b, 0);
        cnt_sel_b = 2'd0;
        tick();
        check("ch0_kept", cnt_out_b, 1);

        // Reset mid-debounce
        sig_in_b = 3'b001;
        for (int e = 0; e < 8; e++) tick();
        check("pre_rst_sig", sig_out_b, 3'b001);
        sig_in_b = 3'b101;
        tick(); tick(); tick(); tick();
        #2;
        rst_b = 1'b1;
        #1;
        check("async_rst_sig", sig_out_b, 0);
        check("async_rst_cnt", cnt_out_b, 0);
        tick(); tick();
        rst_b = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            check($sformatf("rel_sig_e%0d", e), sig_out_b, (e >= 7) ? 3'b101 : 3'b000);
            check($sformatf("rel_rise_e%0d", e), rise_b, (e == 7) ? 3'b101 : 3'b000);
            check($sformatf("rel_cnt_e%0d", e), cnt_out_b, (e >= 9) ? 1 : 0);
        end

        // Asynchronous stress on ch2: counter tracks observed rise pulses
        cnt_sel_b = 2'd2;
        cnt_clr_b = 1'b1;
        tick();
        cnt_clr_b = 1'b0;
        nrise = 0;
        both  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (rise_b[2]) nrise++;
            if (rise_b[2] && fall_b[2]) both = 1'b1;
            #($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) sig_in_b[2] = ~sig_in_b[2];
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rise_b[2]) nrise++;
            if (rise_b[2] && fall_b[2]) both = 1'b1;
        end
        check("stress_cnt", cnt_out_b, nrise);
        check("stress_excl", both, 0);
        check("stress_level", sig_out_b[2], sig_in_b[2]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
